// File: rtl/dmem_lsu.sv
// Load/store unit: one word-aligned req/ack memory transaction per access,
// with load lane extraction/extension, store lane replication and error flagging.
module dmem_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_req,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_lsu_busy,
  output logic        o_lsu_done,
  output logic        o_lsu_err,
  output logic [31:0] o_dmem_output,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_alo;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic        r_err;
  logic        w_err_nxt;
  logic [31:0] r_dout;
  logic        w_accept;
  logic        w_load_ok;

  function automatic logic f_legal(input logic we, input logic [2:0] f3, input logic [1:0] alo);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~alo[0];
      3'b010:  ok = (alo == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~alo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] d;
    case (f3[1:0])
      2'b00:   d = {4{sd[7:0]}};
      2'b01:   d = {2{sd[15:0]}};
      default: d = sd;
    endcase
    return d;
  endfunction

  function automatic logic [3:0] f_wstrb(input logic [2:0] f3, input logic [1:0] alo);
    logic [3:0] s;
    case (f3[1:0])
      2'b00:   s = 4'b0001 << alo;
      2'b01:   s = alo[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] alo,
                                            input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = rd[8*alo +: 8];
    h = rd[16*alo[1] +: 16];
    case (f3)
      3'b000:  v = {{24{b[7]}}, b};
      3'b001:  v = {{16{h[15]}}, h};
      3'b100:  v = {24'h000000, b};
      3'b101:  v = {16'h0000, h};
      default: v = rd;
    endcase
    return v;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Illegal accesses skip REQ entirely; the wait counter tracks REQ cycles without ack.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load_ok   = 1'b0;
    w_err_nxt   = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_lsu_req) begin
          w_accept = 1'b1;
          if (f_legal(i_lsu_we, i_funct3, i_addr[1:0])) begin
            w_state_nxt = S_REQ;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        if (i_mem_ack) begin
          w_state_nxt = S_DONE;
          w_load_ok   = ~r_we;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
          w_cnt_nxt   = r_cnt + 8'd1;
        end else begin
          w_cnt_nxt   = r_cnt + 8'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_alo   <= 2'b00;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_wstrb <= 4'b0000;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
      r_dout  <= 32'h0000_0000;
    end else begin
      if (w_accept) begin
        r_we    <= i_lsu_we;
        r_f3    <= i_funct3;
        r_alo   <= i_addr[1:0];
        r_addr  <= {i_addr[31:2], 2'b00};
        r_wdata <= f_wdata(i_funct3, i_store_data);
        r_wstrb <= i_lsu_we ? f_wstrb(i_funct3, i_addr[1:0]) : 4'b0000;
      end
      if (w_load_ok) begin
        r_dout <= f_extract(r_f3, r_alo, i_mem_rdata);
      end
      r_cnt <= w_cnt_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign o_lsu_busy    = (r_state != S_IDLE);
  assign o_lsu_done    = (r_state == S_DONE);
  assign o_lsu_err     = r_err;
  assign o_dmem_output = r_dout;
  assign o_mem_req     = (r_state == S_REQ);
  assign o_mem_we      = r_we & (r_state == S_REQ);
  assign o_mem_addr    = r_addr;
  assign o_mem_wdata   = r_wdata;
  assign o_mem_wstrb   = r_wstrb;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: stimulus pushes expectations, a negedge monitor
// plays the memory and checks every request and completion against the queues.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        i_rst, i_lsu_req, i_lsu_we, i_mem_ack;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_store_data, i_mem_rdata;
  logic        o_lsu_busy, o_lsu_done, o_lsu_err, o_mem_req, o_mem_we;
  logic [31:0] o_dmem_output, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;

  typedef struct { logic err; logic [31:0] dout; int lat; int nreq; } done_exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic we; } mem_exp_t;

  done_exp_t   sq[$];
  mem_exp_t    mq[$];
  int          total = 0, bad = 0;
  int          cyc = 0, issue_cyc = 0, req_cnt = 0, last_len = 0, ack_at = 0;
  logic [31:0] rdata_v = 32'h0;
  logic        mem_ack_v = 1'b0, force_ack = 1'b0;

  assign i_mem_ack = mem_ack_v | force_ack;

  dmem_lsu #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_lsu_req(i_lsu_req), .i_lsu_we(i_lsu_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_store_data(i_store_data),
    .o_lsu_busy(o_lsu_busy), .o_lsu_done(o_lsu_done), .o_lsu_err(o_lsu_err),
    .o_dmem_output(o_dmem_output), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory responder plus scoreboard monitor, all on the falling edge.
  always @(negedge clk) begin
    mem_exp_t  m;
    done_exp_t d;
    if (o_mem_req) begin
      req_cnt++;
      if (req_cnt == 1) begin
        if (mq.size() == 0) begin
          chk("mem_req_unexpected", 32'd1, 32'd0);
        end else begin
          m = mq.pop_front();
          chk("mem_addr", o_mem_addr, m.addr);
          chk("mem_wstrb", {28'd0, o_mem_wstrb}, {28'd0, m.wstrb});
          chk("mem_we", {31'd0, o_mem_we}, {31'd0, m.we});
          if (m.we) chk("mem_wdata", o_mem_wdata, m.wdata);
        end
      end
      mem_ack_v   = (ack_at != 0) && (req_cnt == ack_at);
      i_mem_rdata = rdata_v;
    end else begin
      if (req_cnt != 0) last_len = req_cnt;
      req_cnt   = 0;
      mem_ack_v = 1'b0;
    end
    if (o_lsu_done) begin
      if (sq.size() == 0) begin
        chk("done_unexpected", 32'd1, 32'd0);
      end else begin
        d = sq.pop_front();
        chk("lsu_err", {31'd0, o_lsu_err}, {31'd0, d.err});
        chk("dmem_output", o_dmem_output, d.dout);
        chk("latency", 32'(cyc - issue_cyc + 1), 32'(d.lat));
        chk("req_cycles", 32'(last_len), 32'(d.nreq));
        chk("busy_in_done", {31'd0, o_lsu_busy}, 32'd1);
      end
      last_len = 0;
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input int ack_i, input logic [31:0] rd,
                       input logic e_err, input logic [31:0] e_dout, input int e_lat,
                       input int e_nreq, input logic [31:0] e_wdata, input logic [3:0] e_strb);
    bit seen_idle = 1'b0;
    @(negedge clk);
    ack_at  = ack_i;
    rdata_v = rd;
    if (e_nreq > 0) mq.push_back('{addr: {a[31:2], 2'b00}, wdata: e_wdata, wstrb: e_strb, we: we});
    sq.push_back('{err: e_err, dout: e_dout, lat: e_lat, nreq: e_nreq});
    i_lsu_we = we; i_funct3 = f3; i_addr = a; i_store_data = sd; i_lsu_req = 1'b1;
    @(posedge clk);
    #1 issue_cyc = cyc;
    i_lsu_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!o_lsu_busy) begin
        seen_idle = 1'b1;
        break;
      end
    end
    if (!seen_idle) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_lsu_req = 1'b0; i_lsu_we = 1'b0; i_funct3 = 3'b000;
    i_addr = 32'h0; i_store_data = 32'h0; i_mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    chk("rst_busy", {31'd0, o_lsu_busy}, 32'd0);
    chk("rst_done", {31'd0, o_lsu_done}, 32'd0);
    chk("rst_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_dout", o_dmem_output, 32'h0);
    chk("rst_wstrb", {28'd0, o_mem_wstrb}, 32'd0);

    //    we    f3      addr          sd            ack rdata         err  dout          lat nreq wdata         strb
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0,        1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 2, 1, 32'h0,        4'b0000);
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0,        1, 32'h80123456, 1'b0, 32'hFFFFFF80, 2, 1, 32'h0,        4'b0000);
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0,        1, 32'h80123456, 1'b0, 32'h00000080, 2, 1, 32'h0,        4'b0000);
    issue(1'b0, 3'b101, 32'h0000_0102, 32'h0,        1, 32'h80123456, 1'b0, 32'h00008012, 2, 1, 32'h0,        4'b0000);
    issue(1'b1, 3'b000, 32'h0000_0201, 32'h000000AB, 1, 32'h0,        1'b0, 32'h00008012, 2, 1, 32'hABABABAB, 4'b0010);
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234CDEF, 2, 32'h0,        1'b0, 32'h00008012, 3, 2, 32'hCDEFCDEF, 4'b1100);
    issue(1'b1, 3'b010, 32'h0000_0300, 32'h11223344, 1, 32'h0,        1'b0, 32'h00008012, 2, 1, 32'h11223344, 4'b1111);
    issue(1'b0, 3'b010, 32'h0000_0102, 32'h0,        1, 32'h0,        1'b1, 32'h00008012, 1, 0, 32'h0,        4'b0000);
    issue(1'b0, 3'b011, 32'h0000_0100, 32'h0,        1, 32'h0,        1'b1, 32'h00008012, 1, 0, 32'h0,        4'b0000);
    issue(1'b1, 3'b100, 32'h0000_0100, 32'h0,        1, 32'h0,        1'b1, 32'h00008012, 1, 0, 32'h0,        4'b0000);
    issue(1'b0, 3'b001, 32'h0000_0101, 32'h0,        1, 32'h0,        1'b1, 32'h00008012, 1, 0, 32'h0,        4'b0000);
    issue(1'b0, 3'b010, 32'h0000_0400, 32'h0,        0, 32'h55555555, 1'b1, 32'h00008012, 5, 4, 32'h0,        4'b0000);
    issue(1'b0, 3'b010, 32'h0000_0404, 32'h0,        4, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 5, 4, 32'h0,        4'b0000);
    issue(1'b0, 3'b001, 32'h0000_0106, 32'h0,        2, 32'h7FFF1234, 1'b0, 32'h00007FFF, 3, 2, 32'h0,        4'b0000);
    issue(1'b0, 3'b001, 32'h0000_0104, 32'h0,        1, 32'h7FFF8001, 1'b0, 32'hFFFF8001, 2, 1, 32'h0,        4'b0000);

    // Reset in the middle of REQ, then a stray ack that must be ignored.
    @(negedge clk);
    ack_at = 0;
    mq.push_back('{addr: 32'h0000_0500, wdata: 32'h0, wstrb: 4'b0000, we: 1'b0});
    i_lsu_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0500; i_lsu_req = 1'b1;
    @(posedge clk);
    #1 i_lsu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("req_before_rst", {31'd0, o_mem_req}, 32'd1);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    force_ack = 1'b1;
    i_mem_rdata = 32'hDEADBEEF;
    chk("post_rst_busy", {31'd0, o_lsu_busy}, 32'd0);
    chk("post_rst_done", {31'd0, o_lsu_done}, 32'd0);
    chk("post_rst_err", {31'd0, o_lsu_err}, 32'd0);
    chk("post_rst_req", {31'd0, o_mem_req}, 32'd0);
    chk("post_rst_we", {31'd0, o_mem_we}, 32'd0);
    chk("post_rst_addr", o_mem_addr, 32'h0);
    chk("post_rst_wdata", o_mem_wdata, 32'h0);
    chk("post_rst_wstrb", {28'd0, o_mem_wstrb}, 32'd0);
    chk("post_rst_dout", o_dmem_output, 32'h0);
    @(negedge clk);
    chk("late_ack_req", {31'd0, o_mem_req}, 32'd0);
    chk("late_ack_dout", o_dmem_output, 32'h0);
    force_ack = 1'b0;
    #1 last_len = 0;

    issue(1'b0, 3'b010, 32'h0000_0104, 32'h0,        1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 2, 1, 32'h0,        4'b0000);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sq.size()), 32'd0);
    chk("mq_drain", 32'(mq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting between the execute stage and the data memory. It issues one word-aligned memory transaction per load or store using a req/ack handshake. For loads, it extracts and sign- or zero-extends the addressed byte, halfword or word. The result is presented as the `dmem_output` operand of the writeback select stage. It also flags misaligned or illegal accesses and memory timeouts so the core can trap.

## Interface
- `TIMEOUT`, 16: maximum cycles `mem_req` is held without `mem_ack` before the access is aborted; legal range 2..255.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `lsu_req` in 1: start an access; sampled only in IDLE.
- `lsu_we` in 1: 1 = store, 0 = load.
- `funct3` in 3: RISC-V width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr` in 32: byte address.
- `store_data` in 32: rs2 value for stores.
- `lsu_busy` out 1: high from acceptance until and including the DONE cycle.
- `lsu_done` out 1: one-cycle completion pulse.
- `lsu_err` out 1: valid with `lsu_done`; 1 = misaligned, illegal `funct3`, or timeout.
- `dmem_output` out 32: extended load result, valid from `lsu_done` until the next load completes.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: store data, lane-replicated.
- `mem_wstrb` out 4: byte enables (0000 on loads).
- `mem_ack` in 1: memory accepted/completed the request; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: read word.

## Operation
- FSM states are IDLE, REQ and DONE.
- IDLE + `lsu_req` latches `lsu_we`, `funct3`, `addr` and `store_data`. The access is then checked:
  - If it is legal, the FSM goes to REQ.
  - If it is illegal, the FSM goes straight to DONE with `lsu_err` = 1 and no memory access.
- Illegal accesses:
  - Any `funct3` outside {000, 001, 010, 100, 101} for loads.
  - Any `funct3` outside {000, 001, 010} for stores.
  - H/HU with `addr[0]` = 1.
  - W with `addr[1:0]` != 00.
- REQ drives `mem_req` = 1. `mem_we`, `mem_addr`, `mem_wdata` and `mem_wstrb` come from the latched values and are stable for the whole REQ period.
- REQ exits to DONE when either of these occurs:
  - `mem_ack` = 1. On a load, `mem_rdata` is captured on that edge.
  - The wait counter reaches `TIMEOUT` without an ack. `lsu_err` is set and `dmem_output` is unchanged.
- DONE asserts `lsu_done` for one cycle, then returns to IDLE.
- Store lanes:
  - SB: `mem_wdata` = {4{sd[7:0]}}, `mem_wstrb` = 0001 << `addr[1:0]`.
  - SH: `mem_wdata` = {2{sd[15:0]}}, `mem_wstrb` = `addr[1]` ? 1100 : 0011.
  - SW: `mem_wdata` = sd, `mem_wstrb` = 1111.
- Load extract:
  - The byte lane is `rdata[8*addr[1:0] +: 8]`.
  - The halfword lane is `rdata[16*addr[1] +: 16]`.
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through.
- `dmem_output` updates only on a successful load. Stores and errored accesses leave it unchanged.
- `lsu_req` outside IDLE is ignored; it is not queued.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset values:
  - FSM = IDLE.
  - `lsu_busy`, `lsu_done`, `lsu_err`, `mem_req` and `mem_we` = 0.
  - `mem_addr`, `mem_wdata` and `dmem_output` = 0.
  - `mem_wstrb` = 0000.
  - Wait counter = 0.
- All outputs are registered or decoded from registered state. There is no combinational path from `mem_ack` or `mem_rdata` to any output.
- Legal access timing: `lsu_req` sampled at edge 0; `mem_req` high from cycle 1.
  - If `mem_ack` is sampled at edge k (k ≥ 1), `mem_req` drops and `lsu_done` is high in cycle k+1.
  - Zero-wait memory (ack in cycle 1) gives `lsu_done` in cycle 2, a latency of 2.
- Illegal access timing: `lsu_done` and `lsu_err` are high in cycle 1, and `mem_req` never asserts.
- Timeout: the counter clears on entry to REQ and increments each REQ cycle without an ack. With no ack, `mem_req` is high for exactly `TIMEOUT` cycles and `lsu_done` + `lsu_err` follow the next cycle.
- An ack arriving in the same cycle the counter hits `TIMEOUT` counts as success.
- Back-to-back: the earliest next acceptance is the cycle after DONE, i.e. IDLE. Throughput is one access per 3 cycles with zero-wait memory.
- `rst` asserted in any state: at the next edge the FSM goes to IDLE, `mem_req` = 0 and no `lsu_done` pulse is produced. A late `mem_ack` after reset is ignored.

## Test plan
- LW at 0x100, memory acks in cycle 1 with rdata 0xDEADBEEF → `mem_addr` = 0x100, `mem_wstrb` = 0000, `lsu_done` in cycle 2, `dmem_output` = 0xDEADBEEF, `lsu_err` = 0.
- LB at 0x103 with rdata 0x80_12_34_56 → 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x00008012.
- SB at 0x201 with sd = 0x000000AB → `mem_addr` = 0x200, `mem_wdata` = 0xABABABAB, `mem_wstrb` = 0010. SH at 0x202 → `mem_wstrb` = 1100. `dmem_output` is unchanged.
- LW at 0x102 → no `mem_req`, `lsu_done` + `lsu_err` in cycle 1. Load with `funct3` = 011 → same response.
- TIMEOUT = 4, no ack → `mem_req` high for 4 cycles, then `lsu_done` + `lsu_err`. Repeat with ack on the 4th cycle → success with `lsu_err` = 0.
- `rst` pulsed during REQ while `mem_ack` is high on the following cycle → all outputs return to reset values, no `lsu_done`. A new LW afterwards completes normally.
